// File: rtl/serial_pkg.sv
// Shared definitions for the serial TX/RX blocks: state encoding, parity modes
// and frame-size helpers.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int char_bits(input int parity, input int stop_bits);
        return 10 + ((parity != PAR_NONE) ? 1 : 0) + (stop_bits - 1);
    endfunction

    function automatic int frame_bits(input int num_bytes, input int parity, input int stop_bits);
        return num_bytes * char_bits(parity, stop_bits);
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: tick marks the last cycle of every CLK_PER_BIT-cycle bit
// period while run is high; the count is held at zero whenever run is low.
module serial_bit_timer #(
    parameter int CLK_PER_BIT = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);

    logic [CNT_W-1:0] count;

    assign tick = run && (count == CNT_W'(CLK_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!run || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_tx_frame.sv
// Multi-byte UART transmitter: sends NUM_BYTES characters back to back, byte 0
// first, LSB first, with optional parity and one or two stop bits.
module serial_tx_frame
    import serial_pkg::*;
#(
    parameter int CLK_PER_BIT = 50,
    parameter int NUM_BYTES   = 6,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    localparam int IDX_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*NUM_BYTES-1:0] data,
    input  logic                   new_data,
    input  logic                   block,
    output logic                   tx,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_W-1:0]       byte_idx
);

    if (CLK_PER_BIT < 2 || NUM_BYTES < 1 || NUM_BYTES > 16 ||
        (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
        $fatal(1, "serial_tx_frame: illegal parameter value");
    end

    state_t                 state, state_n;
    logic [2:0]             bit_cnt, bit_cnt_n;
    logic [IDX_W-1:0]       idx, idx_n;
    logic [8*NUM_BYTES-1:0] frame, frame_n;
    logic [7:0]             cur_byte;
    logic                   block_q, tick, run, done_n, tx_n;

    assign run      = (state != ST_IDLE);
    assign byte_idx = idx;

    serial_bit_timer #(.CLK_PER_BIT(CLK_PER_BIT)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .tick  (tick)
    );

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        idx_n     = idx;
        frame_n   = frame;
        done_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!block_q && new_data) begin
                    state_n   = ST_START;
                    frame_n   = data;
                    bit_cnt_n = '0;
                    idx_n     = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_n   = ST_DATA;
                    bit_cnt_n = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt == 3'd7) begin
                        state_n   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_n   = ST_STOP;
                    bit_cnt_n = '0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt == 3'(STOP_BITS - 1)) begin
                        bit_cnt_n = '0;
                        if (idx == IDX_W'(NUM_BYTES - 1)) begin
                            state_n = ST_IDLE;
                            idx_n   = '0;
                            done_n  = 1'b1;
                        end else begin
                            state_n = ST_START;
                            idx_n   = idx + 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_n   = ST_IDLE;
                bit_cnt_n = '0;
                idx_n     = '0;
            end
        endcase
    end

    // The line level is registered from the next-state values so tx changes
    // on the same edge as the state it belongs to.
    always_comb begin
        cur_byte = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (idx_n == IDX_W'(k)) begin
                cur_byte = frame_n[8*k +: 8];
            end
        end
        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = cur_byte[bit_cnt_n];
            ST_PARITY: tx_n = (PARITY == PAR_ODD) ? ~(^cur_byte) : ^cur_byte;
            default:   tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            idx     <= '0;
            frame   <= '0;
            block_q <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            idx     <= idx_n;
            frame   <= frame_n;
            block_q <= block;
            tx      <= tx_n;
            busy    <= (state_n != ST_IDLE) || block;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_serial_tx_frame.sv
// Scoreboard bench for serial_tx_frame: a line decoder per instance pops the
// expected character words pushed by the directed stimulus.
module tb_serial_tx_frame;

    localparam int CPB = 4;

    typedef struct packed {
        logic [1:0]  dut;
        logic [11:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] data_main;
    logic [7:0]  data_p;
    logic [2:0]  nd;
    logic        block_main, block_p;
    logic [2:0]  tx_bus, done_bus;
    logic        busy_main, busy_even, busy_odd;
    logic [1:0]  idx_main;
    logic [0:0]  idx_even, idx_odd;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serial_tx_frame #(.CLK_PER_BIT(CPB), .NUM_BYTES(3), .PARITY(0), .STOP_BITS(1)) u_main (
        .clk(clk), .rst_n(rst_n), .data(data_main), .new_data(nd[0]), .block(block_main),
        .tx(tx_bus[0]), .busy(busy_main), .done(done_bus[0]), .byte_idx(idx_main)
    );

    serial_tx_frame #(.CLK_PER_BIT(CPB), .NUM_BYTES(1), .PARITY(1), .STOP_BITS(1)) u_even (
        .clk(clk), .rst_n(rst_n), .data(data_p), .new_data(nd[1]), .block(block_p),
        .tx(tx_bus[1]), .busy(busy_even), .done(done_bus[1]), .byte_idx(idx_even)
    );

    serial_tx_frame #(.CLK_PER_BIT(CPB), .NUM_BYTES(1), .PARITY(2), .STOP_BITS(2)) u_odd2 (
        .clk(clk), .rst_n(rst_n), .data(data_p), .new_data(nd[2]), .block(block_p),
        .tx(tx_bus[2]), .busy(busy_odd), .done(done_bus[2]), .byte_idx(idx_odd)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Decodes characters of instance n: nb bits after the start bit, sampled mid-bit.
    task automatic mon_char(input int n, input int nb);
        logic [11:0] w;
        bit          aborted;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_bus[n] === 1'b0) begin
                w       = '0;
                aborted = 1'b0;
                repeat (CPB / 2) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) aborted = 1'b1;
                end
                for (int i = 0; i < nb; i++) begin
                    if (aborted) break;
                    repeat (CPB) begin
                        @(negedge clk);
                        if (rst_n !== 1'b1) aborted = 1'b1;
                    end
                    w = w | (12'(tx_bus[n]) << i);
                end
                if (!aborted) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("[TB] FAIL unexpected char on dut%0d: got %03h, expected none", n, w);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(e.dut) != n || e.word !== w) begin
                            n_fail++;
                            $display("[TB] FAIL char dut%0d: got %03h, expected dut%0d %03h", n, w, e.dut, e.word);
                        end
                    end
                end
            end
        end
    endtask

    initial mon_char(0, 9);
    initial mon_char(1, 10);
    initial mon_char(2, 11);

    task automatic push_frame(input logic [23:0] d);
        for (int b = 0; b < 3; b++) begin
            exp_q.push_back('{dut: 2'd0, word: {4'b0001, d[8*b +: 8]}});
        end
    endtask

    // Called just after the accept edge (start_k edges already elapsed).
    task automatic wait_done(input int n, input int start_k, input int len, input string name);
        int k;
        k = start_k;
        while (done_bus[n] !== 1'b1 && k < len + 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_output(name, k, len);
    endtask

    task automatic apply_stimulus(input int n);
        @(negedge clk);
        nd[n] = 1'b1;
        @(posedge clk);
        #1;
        nd[n] = 1'b0;
    endtask

    initial begin
        int done_cnt, done_at, busy_bad, bad;
        rst_n = 1'b0; nd = '0; block_main = 1'b0; block_p = 1'b0;
        data_main = '0; data_p = '0;

        repeat (2) @(negedge clk);
        check_output("reset tx", tx_bus, 3'b111);
        check_output("reset busy", busy_main, 0);
        check_output("reset done", done_bus, 0);
        check_output("reset byte_idx", idx_main, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame with per-cycle done/busy tracking.
        data_main = 24'hA5_3C_01;
        push_frame(data_main);
        apply_stimulus(0);
        check_output("start after accept tx", tx_bus[0], 0);
        check_output("start after accept busy", busy_main, 1);
        done_cnt = 0; done_at = -1; busy_bad = 0;
        for (int k = 1; k <= 125; k++) begin
            @(posedge clk);
            #1;
            if (done_bus[0]) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k < 120 && busy_main !== 1'b1) busy_bad++;
            if (k == 41)  check_output("byte_idx char1", idx_main, 1);
            if (k == 81)  check_output("byte_idx char2", idx_main, 2);
            if (k == 120) begin
                check_output("busy at end", busy_main, 0);
                check_output("byte_idx at end", idx_main, 0);
            end
        end
        check_output("done cycle", done_at, 120);
        check_output("done count", done_cnt, 1);
        check_output("busy gaps", busy_bad, 0);

        // Parity modes on single-byte instances.
        data_p = 8'h07;
        exp_q.push_back('{dut: 2'd1, word: 12'h307});
        apply_stimulus(1);
        wait_done(1, 0, 44, "even frame length");
        exp_q.push_back('{dut: 2'd2, word: 12'h607});
        apply_stimulus(2);
        wait_done(2, 0, 48, "odd 2-stop frame length");

        // Block holds off requests; release starts a frame two edges later.
        @(negedge clk);
        block_main = 1'b1;
        @(negedge clk);
        check_output("blocked busy", busy_main, 1);
        nd[0] = 1'b1;
        repeat (4) @(negedge clk);
        check_output("blocked tx", tx_bus[0], 1);
        check_output("blocked busy held", busy_main, 1);
        nd[0] = 1'b0;
        @(negedge clk);
        data_main = 24'h12_34_56;
        push_frame(data_main);
        block_main = 1'b0;
        nd[0] = 1'b1;
        @(posedge clk);
        #1;
        check_output("unblock edge1 tx", tx_bus[0], 1);
        check_output("unblock edge1 busy", busy_main, 0);
        @(posedge clk);
        #1;
        nd[0] = 1'b0;
        check_output("unblock edge2 start", tx_bus[0], 0);
        wait_done(0, 0, 120, "frame after unblock");

        // new_data and data changes mid-frame are ignored.
        data_main = 24'hC3_0F_F0;
        push_frame(data_main);
        apply_stimulus(0);
        repeat (50) @(posedge clk);
        #1;
        nd[0] = 1'b1;
        data_main = 24'hFF_FF_FF;
        @(posedge clk);
        #1;
        nd[0] = 1'b0;
        wait_done(0, 51, 120, "frame with ignored inputs");
        bad = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (tx_bus[0] !== 1'b1 || busy_main !== 1'b0) bad++;
        end
        check_output("no second frame", bad, 0);

        // Reset during byte 1 data bit 3 (0xE7 bit 3 is 0).
        data_main = 24'h5A_E7_81;
        push_frame(data_main);
        apply_stimulus(0);
        repeat (57) @(posedge clk);
        #1;
        check_output("tx before reset", tx_bus[0], 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async reset tx", tx_bus[0], 1);
        check_output("async reset busy", busy_main, 0);
        check_output("async reset done", done_bus[0], 0);
        exp_q.delete();
        exp_q.push_back('{dut: 2'd0, word: 12'h181});
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        bad = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done_bus[0] !== 1'b0) bad++;
        end
        check_output("no done after reset", bad, 0);
        data_main = 24'h00_FF_69;
        push_frame(data_main);
        apply_stimulus(0);
        wait_done(0, 0, 120, "frame after reset");

        // Back-to-back frames with new_data held high.
        @(negedge clk);
        data_main = 24'h3B_A2_C4;
        push_frame(data_main);
        push_frame(data_main);
        nd[0] = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 241; k++) begin
            @(posedge clk);
            #1;
            if (k == 130) nd[0] = 1'b0;
            case (k)
                1:   check_output("b2b idx f1c0", idx_main, 0);
                41:  check_output("b2b idx f1c1", idx_main, 1);
                81:  check_output("b2b idx f1c2", idx_main, 2);
                120: begin
                    check_output("b2b done1", done_bus[0], 1);
                    check_output("b2b idle gap busy", busy_main, 0);
                end
                121: begin
                    check_output("b2b second start tx", tx_bus[0], 0);
                    check_output("b2b idx f2c0", idx_main, 0);
                end
                161: check_output("b2b idx f2c1", idx_main, 1);
                201: check_output("b2b idx f2c2", idx_main, 2);
                241: check_output("b2b done2", done_bus[0], 1);
                default: ;
            endcase
        end

        bad = 0;
        while (exp_q.size() != 0 && bad < 200) begin
            @(posedge clk);
            bad++;
        end
        check_output("scoreboard drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/serial_tx_frame.md
Name: serial_tx_frame

Overview:
Parametrised UART transmitter that serialises a NUM_BYTES-wide word as back-to-back 8N1/8E1/8O1/8N2-style characters, byte 0 first, LSB first. It is the next generation of the fixed 6-byte frame transmitter, adding configurable frame length, parity, stop-bit count, a completion pulse and a byte-index output. It sits between the packet assembler and the board TX pin; `block` lets the host-side flow control hold off new frames.

Parameters:
- CLK_PER_BIT, 50, clock cycles per serial bit; legal range ≥ 2.
- NUM_BYTES, 6, characters per frame; legal range 1..16.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per character; legal values 1 or 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data  in  8*NUM_BYTES  frame payload; byte k = data[8k+7:8k].
- new_data  in  1  request strobe; sampled only in IDLE.
- block  in  1  flow-control hold-off; registered before use.
- tx  out  1  serial line, registered; idles high.
- busy  out  1  registered; high while blocked or while a frame is in flight.
- done  out  1  registered; one-cycle pulse at the end of a frame.
- byte_idx  out  $clog2(NUM_BYTES) (min 1)  index of the character currently on the line; 0 in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, tx = 1, busy = 0, done = 0, byte_idx = 0, all counters = 0, block_q = 0.
- block is registered once (block_q). In IDLE:
  - If block_q = 1: busy = 1, tx = 1, and new_data is ignored.
  - Else busy = 0, and the block is ready.
- Accept condition: IDLE, block_q = 0 and new_data = 1.
  - data is latched in that same cycle.
  - Next cycle: state = START, tx = 0, busy = 1.
- Every bit period is exactly CLK_PER_BIT cycles, counted by a $clog2(CLK_PER_BIT)-bit counter that wraps to 0 at CLK_PER_BIT-1.
- State sequence per character: START (1 bit) → DATA (8 bits, bit 0 first) → PARITY (1 bit, only if PARITY ≠ 0) → STOP (STOP_BITS bits, tx = 1).
- Parity bit value:
  - Even mode: XOR of the 8 data bits.
  - Odd mode: inverted XOR of the 8 data bits.
- At the end of the last STOP bit:
  - If byte_idx < NUM_BYTES-1: byte_idx increments and the next state is START. There is no idle gap between characters.
  - Else: the next state is IDLE, done = 1 for exactly one cycle, busy drops in the same cycle (unless block_q = 1), and byte_idx returns to 0.
- Frame length in cycles: NUM_BYTES × (10 + (PARITY ≠ 0) + (STOP_BITS−1)) × CLK_PER_BIT.
- new_data while not in IDLE is ignored; no queuing.
- data changes after the accept cycle have no effect on the frame in flight.
- block asserted mid-frame does not truncate the frame; it takes effect at the return to IDLE.
- new_data and block_q both high in IDLE: block wins and nothing is sent.
- An illegal parameter value fails elaboration.
- Reset asserted mid-frame: the line returns high immediately (asynchronous); no done pulse; the partial frame is discarded.
- Default case of the state machine forces IDLE.

Decomposition:
- Package `serial_pkg` holds:
  - State encoding: IDLE, START, DATA, PARITY, STOP (3 bits).
  - Parity mode constants: PAR_NONE = 0, PAR_EVEN = 1, PAR_ODD = 2.
  - Helper function for frame bit count.
- One sub-module: `serial_bit_timer` (parameter CLK_PER_BIT; inputs clk, rst_n, run; output tick).
  - tick is a one-cycle pulse on the last cycle of each bit period.
  - The counter clears whenever run = 0.
  - The receiver will reuse this sub-module.

Test Plan:
- Single frame, default framing: CLK_PER_BIT=4, NUM_BYTES=3, PARITY=0, STOP_BITS=1, data=24'hA5_3C_01, one-cycle new_data.
  - Decoded line must be 0x01, 0x3C, 0xA5 in that order.
  - Frame lasts 120 cycles.
  - done pulses once, at cycle 120 after accept.
  - busy is high for cycles 1..119.
- Parity modes: NUM_BYTES=1, data=8'h07.
  - PARITY=1 (even) gives parity bit 1; PARITY=2 (odd) gives parity bit 0.
  - Frame is 11 bit-times.
  - With STOP_BITS=2, frame is 12 bit-times and the line is high for the last 2.
- Block handling: block high before the request, then new_data pulses.
  - tx stays 1, busy = 1, no frame is sent.
  - After block drops, a fresh new_data starts a frame 2 cycles later (1 cycle block register + 1 cycle accept).
- Ignored inputs mid-frame: new_data re-pulsed and data changed mid-frame.
  - The transmitted bytes equal the original latch.
  - No second frame follows.
- Reset mid-frame: rst_n pulsed low during byte 1, DATA bit 3.
  - tx goes to 1 and busy to 0 asynchronously; no done pulse.
  - The next request transmits a full correct frame.
- Back-to-back frames: new_data held high continuously.
  - Consecutive frames are separated by exactly one IDLE cycle.
  - byte_idx sequences 0..NUM_BYTES-1 in each frame.
